// File: rtl/event_encoder_4to2.sv
`default_nettype none
// ============================================================================
// Module      : event_encoder_4to2
// Description : Captures multi-hot event requests into a pending register and
//               emits them one at a time as binary indices on a valid/ready
//               channel. Optional macro EVENT_ENC_ROUND_ROBIN_EN selects
//               rotating priority instead of fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module event_encoder_4to2 #(
    parameter int N_IN  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  pending,
    output logic             overflow
);

    generate
        if ((N_IN < 2) || ((N_IN & (N_IN - 1)) != 0)) begin : g_bad_n_in
            $error("event_encoder_4to2: N_IN must be a power of two >= 2");
        end
        if (IDX_W != $clog2(N_IN)) begin : g_bad_idx_w
            $error("event_encoder_4to2: IDX_W must equal clog2(N_IN)");
        end
    endgenerate

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;
    localparam logic [N_IN-1:0] c_one = {{(N_IN-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [N_IN-1:0]  r_pending;
    logic             r_overflow;

    logic             w_hs;
    logic [N_IN-1:0]  w_clr;
    logic [N_IN-1:0]  w_eff;
    logic             w_ovf;
    logic [IDX_W-1:0] w_pick;

    assign w_hs  = (r_state == S_FULL) & out_ready;
    assign w_clr = w_hs ? (c_one << r_idx) : '0;
    // A request landing on the bit being cleared re-sets it, so no event is lost.
    assign w_eff = (r_pending & ~w_clr) | req;
    assign w_ovf = |(req & r_pending & ~w_clr);

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= r_idx;
        end
    end

    // On a handshake the index leaving now is the most recent transfer.
    assign w_base = w_hs ? r_idx : r_ptr;

    always_comb begin
        logic [IDX_W-1:0] cand;
        w_pick = '0;
        cand   = '0;
        for (int k = N_IN; k >= 1; k--) begin
            cand = w_base + IDX_W'(k);
            if (w_eff[cand]) begin
                w_pick = cand;
            end
        end
    end
`else
    always_comb begin
        w_pick = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (w_eff[k]) begin
                w_pick = IDX_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_idx      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_eff;
            r_overflow <= w_ovf;
            case (r_state)
                S_EMPTY: begin
                    if (|w_eff) begin
                        r_idx   <= w_pick;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_hs) begin
                        if (|w_eff) begin
                            r_idx <= w_pick;
                        end else begin
                            r_state <= S_EMPTY;
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign out_idx   = r_idx;
    assign out_valid = (r_state == S_FULL);
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_4to2.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_encoder_4to2
// Description : Self-checking bench for event_encoder_4to2 with a set-based
//               reference model and directed plus random scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder_4to2;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: a set of pending events plus one presented slot.
    logic [3:0] m_pend;
    bit         m_valid;
    int         m_idx;
    int         m_last;
    bit         m_ovf;

    event_encoder_4to2 #(.N_IN(4), .IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] v, int last);
`ifdef EVENT_ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) return j;
        end
`else
        for (int j = 0; j < N; j++) begin
            if (v[j]) return j;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 0;
        m_idx   = 0;
        m_last  = 0;
        m_ovf   = 0;
    endtask

    // Advance one clock; the model consumes the inputs seen at the edge.
    task automatic tick();
        bit         hs;
        logic [3:0] nxt;
        @(posedge clk);
        hs    = m_valid && out_ready;
        m_ovf = 0;
        nxt   = '0;
        for (int i = 0; i < N; i++) begin
            bit kept;
            kept = m_pend[i] && !(hs && i == m_idx);
            if (kept && req[i]) m_ovf = 1;
            nxt[i] = kept || req[i];
        end
        m_pend = nxt;
        if (hs) m_last = m_idx;
        if (!m_valid || hs) begin
            if (nxt != 0) begin
                m_valid = 1;
                m_idx   = pick(nxt, m_last);
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_idx, pending, overflow} !== 8'h00) begin
            bad++;
            $display("FAIL reset: got valid=%0b idx=%0d pend=%b ovf=%0b required all zero",
                     out_valid, out_idx, pending, overflow);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%0b pend=%b required 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_single_event();
        req = 4'b0100; out_ready = 1'b1;
        tick();
        req = '0;
        total++;
        if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
            bad++;
            $display("FAIL single_present: got valid=%0b idx=%0d required 1/2", out_valid, out_idx);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL single_drain: got valid=%0b pend=%b required 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_multi_hot();
        int exp_idx [3];
        exp_idx = '{0, 1, 3};
        req = 4'b1011; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            req = '0;
`ifndef EVENT_ENC_ROUND_ROBIN_EN
            total++;
            if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx[k])) begin
                bad++;
                $display("FAIL multi_hot[%0d]: got valid=%0b idx=%0d required 1/%0d",
                         k, out_valid, out_idx, exp_idx[k]);
            end
`else
            total++;
            if (out_valid !== 1'b1 || out_idx !== 2'(m_idx)) begin
                bad++;
                $display("FAIL multi_hot[%0d]: got valid=%0b idx=%0d required 1/%0d",
                         k, out_valid, out_idx, m_idx);
            end
`endif
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL multi_hot_drain: got valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        req = 4'b0010; out_ready = 1'b0;
        tick();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
                bad++;
                $display("FAIL backpressure[%0d]: got valid=%0b idx=%0d required 1/1",
                         k, out_valid, out_idx);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL backpressure_release: got valid=%0b pend=%b required 0/0000",
                     out_valid, pending);
        end
    endtask

    task automatic test_overflow();
        bit exp_ovf [3];
        exp_ovf = '{0, 1, 1};
        req = 4'b0001; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (overflow !== exp_ovf[k]) begin
                bad++;
                $display("FAIL overflow[%0d]: got %0b required %0b", k, overflow, exp_ovf[k]);
            end
        end
        req = '0;
        tick();
        total++;
        if (overflow !== 1'b0 || out_idx !== 2'd0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL overflow_end: got ovf=%0b valid=%0b idx=%0d required 0/1/0",
                     overflow, out_valid, out_idx);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL overflow_single_xfer: got valid=%0b pend=%b required 0/0000",
                     out_valid, pending);
        end
    endtask

    task automatic test_clear_rerequest();
        req = 4'b1000; out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        req = '0;
        total++;
        if (pending[3] !== 1'b1 || overflow !== 1'b0 || out_valid !== 1'b1 || out_idx !== 2'd3) begin
            bad++;
            $display("FAIL clear_rerequest: got pend=%b ovf=%0b valid=%0b idx=%0d required 1xxx/0/1/3",
                     pending, overflow, out_valid, out_idx);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL clear_rerequest_drain: got valid=%0b pend=%b required 0/0000",
                     out_valid, pending);
        end
    endtask

    task automatic test_async_reset();
        req = 4'b1110; out_ready = 1'b0;
        tick();
        req = '0;
        total++;
        if (pending !== 4'b1110 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL async_setup: got pend=%b valid=%0b required 1110/1", pending, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_idx, pending, overflow} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got valid=%0b idx=%0d pend=%b ovf=%0b required all zero",
                     out_valid, out_idx, pending, overflow);
        end
        model_reset();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    task automatic test_round_robin();
        int exp_idx [6];
        exp_idx = '{1, 2, 3, 0, 1, 2};
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx[k])) begin
                bad++;
                $display("FAIL round_robin[%0d]: got valid=%0b idx=%0d required 1/%0d",
                         k, out_valid, out_idx, exp_idx[k]);
            end
        end
        req = '0;
        repeat (5) tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req       = 4'($urandom) & 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if (out_valid !== m_valid || pending !== m_pend || overflow !== m_ovf ||
                (m_valid && out_idx !== 2'(m_idx))) begin
                bad++;
                $display("FAIL random[%0d]: got valid=%0b idx=%0d pend=%b ovf=%0b required %0b/%0d/%b/%0b",
                         c, out_valid, out_idx, pending, overflow, m_valid, m_idx, m_pend, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_multi_hot();
        test_backpressure();
        test_overflow();
        test_clear_rerequest();
        test_async_reset();
`ifdef EVENT_ENC_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
